// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   state_e     : sequencer FSM states
//   pipe_ctrl_t : every stall/flush control bit driven into the pipe
//   REG_IDX_W   : architectural register index width
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DWAIT = 2'd2,
    IWAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (pure combinational).
// Ports:
//   id_rs1_i, id_rs2_i : source indices of the instruction in ID
//   id_uses_rs2_i      : ID instruction actually reads rs2
//   ex_rd_i            : destination of the instruction in EX
//   ex_is_load_i       : EX instruction is a load
//   hazard_o           : ID must wait one cycle for the load result
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs2_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_is_load_i,
  output logic                 hazard_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_is_load_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Inputs : ID/EX register indices and load flag, EX redirect, imem/dmem
//          request/ready handshakes.
// Outputs: pc_stall, IF2ID/ID2EX/EX2MEM stall+flush, MEM2WB flush (all
//          combinational from state and inputs), sticky timeout_err.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds perf_dstall, perf_istall,
// perf_lu and perf_flush counters (CNT_W bits, wrapping, idle during INIT).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 imem_req,
  input  logic                 imem_ready,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [CNT_W-1:0]     perf_dstall,
  output logic [CNT_W-1:0]     perf_istall,
  output logic [CNT_W-1:0]     perf_lu,
  output logic [CNT_W-1:0]     perf_flush,
`endif
  output logic                 timeout_err
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  // The cycle that first sees a miss already stalls, so the release happens
  // in the wait-state cycle that would have been stall number TIMEOUT_CYCLES+1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [INIT_W-1:0]   init_q, init_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  pipe_ctrl_t          ctrl;
  logic                lu_hz, dmiss, tmo, hz_en, ihold, dfreeze;

  load_use_detect u_lud (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_rd_i       (ex_rd),
    .ex_is_load_i  (ex_is_load),
    .hazard_o      (lu_hz)
  );

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ctrl    = '0;
    hz_en   = 1'b0;
    ihold   = 1'b0;
    dfreeze = 1'b0;
    dmiss   = dmem_req && !dmem_ready;
    tmo     = (wait_q == WAIT_LAST);

    unique case (state_q)
      INIT: begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
        if (init_q == INIT_LAST) state_d = RUN;
        else                     init_d  = INIT_W'(init_q + 1'b1);
      end
      RUN: begin
        hz_en  = 1'b1;
        wait_d = '0;
        if (dmiss) begin
          dfreeze = 1'b1;
          state_d = DWAIT;
        end else if (imem_req && !imem_ready) begin
          ihold   = 1'b1;
          state_d = IWAIT;
        end
      end
      IWAIT: begin
        if (dmiss) begin
          // Data wait wins; a fresh access starts its own watchdog window.
          dfreeze = 1'b1;
          state_d = DWAIT;
          wait_d  = '0;
        end else begin
          hz_en = 1'b1;
          if (imem_ready) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (tmo) begin
            state_d = RUN;
            wait_d  = '0;
            err_d   = 1'b1;
          end else begin
            ihold  = 1'b1;
            wait_d = WAIT_W'(wait_q + 1'b1);
          end
        end
      end
      DWAIT: begin
        // Ready and timeout cycles behave like RUN: the held EX instruction
        // advances now, so a pending redirect must be honoured here.
        if (dmem_ready || tmo) begin
          hz_en   = 1'b1;
          state_d = RUN;
          wait_d  = '0;
          if (!dmem_ready) err_d = 1'b1;
        end else begin
          dfreeze = 1'b1;
          wait_d  = WAIT_W'(wait_q + 1'b1);
        end
      end
      default: state_d = INIT;
    endcase

    if (dfreeze) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (hz_en) begin
      if (ihold) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_flush = 1'b1;
      end
      if (ex_redirect) begin
        // The redirect target must load into PC even while a fetch is pending.
        ctrl.pc_stall    = 1'b0;
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end else if (lu_hz) begin
        // Hold the dependent instruction in ID; a flush would discard it.
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.if_id_flush = 1'b0;
        ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= INIT;
      init_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign timeout_err  = err_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] dstall_q, istall_q, lu_q, flush_q;
  logic             lu_evt, rd_evt;

  // Both patterns are unique to their event: INIT has no if_id_stall, and
  // every INIT/stall cycle has pc_stall high while a redirect never does.
  assign lu_evt = ctrl.if_id_stall && ctrl.id_ex_flush;
  assign rd_evt = ctrl.if_id_flush && ctrl.id_ex_flush && !ctrl.pc_stall;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      dstall_q <= '0;
      istall_q <= '0;
      lu_q     <= '0;
      flush_q  <= '0;
    end else begin
      if (state_q == DWAIT) dstall_q <= dstall_q + 1'b1;
      if (state_q == IWAIT) istall_q <= istall_q + 1'b1;
      if (lu_evt)           lu_q     <= lu_q + 1'b1;
      if (rd_evt)           flush_q  <= flush_q + 1'b1;
    end
  end

  assign perf_dstall = dstall_q;
  assign perf_istall = istall_q;
  assign perf_lu     = lu_q;
  assign perf_flush  = flush_q;
`else
  // Keeps CNT_W referenced in the lean build; carries no logic.
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (INIT_CYCLES=2, TIMEOUT_CYCLES=4).
// The driver applies one input vector per cycle just after the rising edge and
// queues the hand-computed output vector; the monitor pops and compares on the
// falling edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       ireq;
    logic       irdy;
    logic       dreq;
    logic       drdy;
  } stim_t;

  // {timeout_err, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  //  id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush}
  localparam logic [8:0] E_ERR = 9'h100, E_PC  = 9'h080, E_IFS = 9'h040,
                         E_IFF = 9'h020, E_IES = 9'h010, E_IEF = 9'h008,
                         E_EMS = 9'h004, E_EMF = 9'h002, E_MWF = 9'h001;
  localparam logic [8:0] E_INIT = E_PC | E_IFF | E_IEF | E_EMF | E_MWF;
  localparam logic [8:0] E_LU   = E_PC | E_IFS | E_IEF;
  localparam logic [8:0] E_DW   = E_PC | E_IFS | E_IES | E_EMS | E_MWF;
  localparam logic [8:0] E_IW   = E_PC | E_IFF;
  localparam logic [8:0] E_RD   = E_IFF | E_IEF;
  localparam logic [8:0] E_NONE = 9'h000;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, ex_is_load = 1'b0, ex_redirect = 1'b0;
  logic       imem_req = 1'b0, imem_ready = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, timeout_err;
  logic [8:0] act;

  logic [8:0] expq[$];
  string      nameq[$];
  int         total = 0;
  int         bad = 0;

  always #5 ACLK = ~ACLK;

  pipe_hazard_ctrl #(.INIT_CYCLES(2), .TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .timeout_err  (timeout_err)
  );

  assign act = {timeout_err, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush};

  task automatic cyc(input logic rn, input stim_t s, input logic [8:0] e, input string nm);
    @(posedge ACLK);
    #1;
    ARESETn     = rn;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_uses_rs2 = s.u2;
    ex_rd       = s.rd;
    ex_is_load  = s.ld;
    ex_redirect = s.redir;
    imem_req    = s.ireq;
    imem_ready  = s.irdy;
    dmem_req    = s.dreq;
    dmem_ready  = s.drdy;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  always @(negedge ACLK) begin
    if (expq.size() > 0) begin
      logic [8:0] e;
      string      n;
      e = expq.pop_front();
      n = nameq.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %b expected %b", n, act, e);
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    // Reset and startup flush
    cyc(1'b0, s, E_INIT, "rst_hold");
    cyc(1'b1, s, E_INIT, "init1");
    cyc(1'b1, s, E_INIT, "init2");
    cyc(1'b1, s, E_NONE, "run_idle");
    // Load-use
    s = '0; s.ld = 1; s.rd = 5'd5; s.rs1 = 5'd5;
    cyc(1'b1, s, E_LU, "lu_rs1");
    s = '0;
    cyc(1'b1, s, E_NONE, "lu_gone");
    s = '0; s.ld = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1; s.rs1 = 5'd3;
    cyc(1'b1, s, E_LU, "lu_rs2");
    s.u2 = 0;
    cyc(1'b1, s, E_NONE, "lu_rs2_unused");
    s = '0; s.ld = 1; s.rd = 5'd0; s.rs1 = 5'd0;
    cyc(1'b1, s, E_NONE, "lu_x0");
    // Redirect priority
    s = '0; s.ld = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.redir = 1;
    cyc(1'b1, s, E_RD, "redir_over_lu");
    s = '0; s.redir = 1;
    cyc(1'b1, s, E_RD, "redir");
    // Data wait: 3 miss cycles, redirect masked, release in ready cycle
    s = '0; s.dreq = 1;
    cyc(1'b1, s, E_DW, "dmiss1");
    s.redir = 1;
    cyc(1'b1, s, E_DW, "dmiss2_redir");
    s.redir = 0;
    cyc(1'b1, s, E_DW, "dmiss3");
    s.drdy = 1;
    cyc(1'b1, s, E_NONE, "dready");
    s = '0;
    cyc(1'b1, s, E_NONE, "post_d");
    // Fetch wait with redirect, then data miss takes priority
    s = '0; s.ireq = 1;
    cyc(1'b1, s, E_IW, "imiss");
    s.redir = 1;
    cyc(1'b1, s, E_RD, "iwait_redir");
    s.redir = 0; s.dreq = 1;
    cyc(1'b1, s, E_DW, "iwait_dmiss");
    cyc(1'b1, s, E_DW, "dwait_from_i");
    s = '0; s.dreq = 1; s.drdy = 1;
    cyc(1'b1, s, E_NONE, "dready2");
    s = '0;
    cyc(1'b1, s, E_NONE, "idle2");
    // Watchdog: 4 stalled cycles, forced release, sticky error
    s = '0; s.ireq = 1;
    for (int i = 0; i < 4; i++) cyc(1'b1, s, E_IW, $sformatf("to_stall%0d", i));
    cyc(1'b1, s, E_NONE, "to_release");
    s = '0;
    cyc(1'b1, s, E_ERR, "err_sticky1");
    cyc(1'b1, s, E_ERR, "err_sticky2");
    s.ld = 1; s.rd = 5'd9; s.rs1 = 5'd9;
    cyc(1'b1, s, E_ERR | E_LU, "err_lu");
    // Reset mid-operation clears the error and replays INIT
    s = '0;
    cyc(1'b0, s, E_INIT, "rst2");
    cyc(1'b1, s, E_INIT, "re_init1");
    cyc(1'b1, s, E_INIT, "re_init2");
    cyc(1'b1, s, E_NONE, "re_run");
    // Fetch wait with normal completion
    s.ireq = 1;
    cyc(1'b1, s, E_IW, "imiss2");
    s.irdy = 1;
    cyc(1'b1, s, E_NONE, "iready");
    s = '0;
    cyc(1'b1, s, E_NONE, "post_i");
    // Simultaneous fetch and data miss in RUN
    s.ireq = 1; s.dreq = 1;
    cyc(1'b1, s, E_DW, "both_miss");
    s = '0; s.dreq = 1; s.drdy = 1;
    cyc(1'b1, s, E_NONE, "dready3");
    s = '0;
    cyc(1'b1, s, E_NONE, "final_idle");

    repeat (2) @(posedge ACLK);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
